// File: rtl/cpu_pkg.sv
// Shared encodings for simple_cpu: opcodes, controller states and datapath select codes.
// The datapath decode imports this package as well.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_FWAIT  = 3'd2,
        ST_DECODE = 3'd3,
        ST_MWAIT  = 3'd4,
        ST_EXEC   = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] ACC_SRC_IMM = 2'd0;
    localparam logic [1:0] ACC_SRC_MEM = 2'd1;
    localparam logic [1:0] ACC_SRC_ALU = 2'd2;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    // Opcodes that need a data-RAM operand read before EXEC.
    function automatic logic is_mem_op(input logic [3:0] op);
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: is_mem_op = 1'b1;
            default:                               is_mem_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for simple_cpu: FETCH, FWAIT, DECODE, optional MWAIT, EXEC, with
// run/single-step control and a sticky HALT. Strobes decode combinationally from state + opcode.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk_50mhz,
    input  logic             key0_n,
    input  logic             run_en,
    input  logic             step_req,
    input  logic [3:0]       opcode,
    input  logic             acc_zero,
    input  logic             carry_flag,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             ir_load,
    output logic             addr_sel,
    output logic             mem_rd,
    output logic             mem_we,
    output logic             acc_load,
    output logic [1:0]       acc_src,
    output logic [1:0]       alu_op,
    output logic             flags_load,
    output logic             halted,
    output logic             illegal,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [1:0] WAIT_INIT = 2'(MEM_LATENCY - 1);

    state_t           r_state;
    logic [1:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_instr_count;

    state_t w_next;
    logic   w_complete;
    logic   w_wait_load;

    // Next-state and strobe decode from the registered state and the IR opcode.
    always_comb begin
        w_next      = r_state;
        w_complete  = 1'b0;
        w_wait_load = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        ir_load     = 1'b0;
        addr_sel    = 1'b0;
        mem_rd      = 1'b0;
        mem_we      = 1'b0;
        acc_load    = 1'b0;
        acc_src     = ACC_SRC_IMM;
        alu_op      = ALU_ADD;
        flags_load  = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run_en || step_req) begin
                    w_next = ST_FETCH;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                mem_rd      = 1'b1;
                w_wait_load = 1'b1;
                w_next      = ST_FWAIT;
            end
            ST_FWAIT: begin
                if (r_wait_cnt == 2'd0) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    w_next  = ST_DECODE;
                end else begin
                    w_next  = ST_FWAIT;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_NOP: w_complete = 1'b1;
                    OP_LDI: begin
                        acc_load   = 1'b1;
                        acc_src    = ACC_SRC_IMM;
                        w_complete = 1'b1;
                    end
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        mem_rd      = 1'b1;
                        addr_sel    = 1'b1;
                        w_wait_load = 1'b1;
                        w_next      = ST_MWAIT;
                    end
                    OP_STA: begin
                        mem_we     = 1'b1;
                        addr_sel   = 1'b1;
                        w_complete = 1'b1;
                    end
                    OP_JMP: begin
                        pc_load    = 1'b1;
                        w_complete = 1'b1;
                    end
                    OP_JZ: begin
                        pc_load    = acc_zero;
                        w_complete = 1'b1;
                    end
                    OP_JC: begin
                        pc_load    = carry_flag;
                        w_complete = 1'b1;
                    end
                    OP_HLT: w_next = ST_HALT;
                    default: begin
                        illegal    = 1'b1;
                        w_complete = 1'b1;
                    end
                endcase
            end
            ST_MWAIT: begin
                if (r_wait_cnt == 2'd0) begin
                    w_next = ST_EXEC;
                end else begin
                    w_next = ST_MWAIT;
                end
            end
            ST_EXEC: begin
                if (opcode == OP_LDA) begin
                    acc_load = 1'b1;
                    acc_src  = ACC_SRC_MEM;
                end else if (is_mem_op(opcode)) begin
                    acc_load   = 1'b1;
                    acc_src    = ACC_SRC_ALU;
                    alu_op     = 2'(opcode - OP_ADD);
                    flags_load = 1'b1;
                end else begin
                    acc_load = 1'b0;
                end
                w_complete = 1'b1;
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IDLE;
        endcase
        // Retiring instructions chain straight into the next fetch only while free-running.
        if (w_complete) begin
            w_next = run_en ? ST_FETCH : ST_IDLE;
        end else begin
            w_complete = 1'b0;
        end
    end

    // State register, RAM wait counter and retired-instruction counter.
    always_ff @(posedge clk_50mhz or negedge key0_n) begin
        if (!key0_n) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= 2'd0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_wait_load) begin
                r_wait_cnt <= WAIT_INIT;
            end else if (((r_state == ST_FWAIT) || (r_state == ST_MWAIT)) && (r_wait_cnt != 2'd0)) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end
            if (w_complete) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    assign halted      = (r_state == ST_HALT);
    assign state_out   = r_state;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: a tiny PC/IR/RAM model feeds opcodes back to the controller;
// single-step vector table plus directed run, reset and MEM_LATENCY=3 sequences.
module tb_cpu_control_unit;

    logic        clk_50mhz = 1'b0;
    logic        key0_n = 1'b0;
    logic        run_en = 1'b0, step_req = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        acc_zero = 1'b0, carry_flag = 1'b0;
    logic        pc_inc, pc_load, ir_load, addr_sel, mem_rd, mem_we, acc_load, flags_load;
    logic        halted, illegal;
    logic [1:0]  acc_src, alu_op;
    logic [2:0]  state_out;
    logic [15:0] instr_count;

    logic        run3 = 1'b0, step3 = 1'b0;
    logic [3:0]  op3 = 4'h0;
    logic        p3_inc, p3_load, ir3_load, addr3_sel, rd3, we3, acc3_load, fl3_load, halted3, ill3;
    logic [1:0]  src3, alu3;
    logic [2:0]  state3;
    logic [15:0] cnt3;

    logic [15:0] ram [256];
    logic [15:0] ir;
    logic [7:0]  pc;
    int          n_chk = 0, n_err = 0;
    int          exp_cnt = 0;

    typedef struct {
        logic [15:0] instr;
        logic        az;
        logic        cy;
        logic [7:0]  dec;
        logic [5:0]  exe;
        int          cycles;
        logic [7:0]  pc_after;
    } vec_t;
    vec_t tbl [16];

    cpu_control_unit #(.MEM_LATENCY(1), .CNT_W(16)) dut (
        .clk_50mhz(clk_50mhz), .key0_n(key0_n), .run_en(run_en), .step_req(step_req),
        .opcode(opcode), .acc_zero(acc_zero), .carry_flag(carry_flag),
        .pc_inc(pc_inc), .pc_load(pc_load), .ir_load(ir_load), .addr_sel(addr_sel),
        .mem_rd(mem_rd), .mem_we(mem_we), .acc_load(acc_load), .acc_src(acc_src),
        .alu_op(alu_op), .flags_load(flags_load), .halted(halted), .illegal(illegal),
        .state_out(state_out), .instr_count(instr_count)
    );

    cpu_control_unit #(.MEM_LATENCY(3), .CNT_W(16)) dut3 (
        .clk_50mhz(clk_50mhz), .key0_n(key0_n), .run_en(run3), .step_req(step3),
        .opcode(op3), .acc_zero(1'b0), .carry_flag(1'b0),
        .pc_inc(p3_inc), .pc_load(p3_load), .ir_load(ir3_load), .addr_sel(addr3_sel),
        .mem_rd(rd3), .mem_we(we3), .acc_load(acc3_load), .acc_src(src3),
        .alu_op(alu3), .flags_load(fl3_load), .halted(halted3), .illegal(ill3),
        .state_out(state3), .instr_count(cnt3)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dec_vec();
        return {mem_rd, mem_we, addr_sel, pc_load, acc_load, acc_src, illegal};
    endfunction

    function automatic logic [5:0] exe_vec();
        return {acc_load, acc_src, alu_op, flags_load};
    endfunction

    function automatic logic [15:0] all_strobes();
        return {pc_inc, pc_load, ir_load, addr_sel, mem_rd, mem_we, acc_load, acc_src,
                alu_op, flags_load, halted, illegal};
    endfunction

    // One clock: latch strobes, let the edge pass, then update the PC/IR model and re-drive opcode.
    task automatic cyc();
        logic l_ir, l_inc, l_pl;
        l_ir = ir_load; l_inc = pc_inc; l_pl = pc_load;
        @(posedge clk_50mhz);
        #1;
        if (l_ir) ir = ram[pc];
        if (l_pl) pc = ir[7:0];
        else if (l_inc) pc = pc + 8'd1;
        opcode = ir[15:12];
        #1;
    endtask

    task automatic do_reset();
        run_en = 1'b0; step_req = 1'b0; run3 = 1'b0; step3 = 1'b0;
        pc = 8'h00; ir = 16'h0000; opcode = 4'h0;
        key0_n = 1'b0;
        repeat (2) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        key0_n = 1'b1;
        @(posedge clk_50mhz);
        #2;
        exp_cnt = 0;
    endtask

    initial begin
        logic [7:0] d;
        logic [5:0] e;
        int         n;
        logic [2:0] exp_st [7];
        logic [2:0] st3 [10];
        logic       ild3 [10];

        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        tbl[0]  = '{16'h0000, 1'b0, 1'b0, 8'h00, 6'h00, 3, 8'h01};
        tbl[1]  = '{16'h102A, 1'b0, 1'b0, 8'h08, 6'h00, 3, 8'h01};
        tbl[2]  = '{16'h2005, 1'b0, 1'b0, 8'hA0, 6'h28, 5, 8'h01};
        tbl[3]  = '{16'h3007, 1'b0, 1'b0, 8'h60, 6'h00, 3, 8'h01};
        tbl[4]  = '{16'h4005, 1'b0, 1'b0, 8'hA0, 6'h31, 5, 8'h01};
        tbl[5]  = '{16'h5005, 1'b0, 1'b0, 8'hA0, 6'h33, 5, 8'h01};
        tbl[6]  = '{16'h6005, 1'b0, 1'b0, 8'hA0, 6'h35, 5, 8'h01};
        tbl[7]  = '{16'h7005, 1'b0, 1'b0, 8'hA0, 6'h37, 5, 8'h01};
        tbl[8]  = '{16'h8010, 1'b0, 1'b0, 8'h10, 6'h00, 3, 8'h10};
        tbl[9]  = '{16'h9010, 1'b0, 1'b1, 8'h00, 6'h00, 3, 8'h01};
        tbl[10] = '{16'h9010, 1'b1, 1'b0, 8'h10, 6'h00, 3, 8'h10};
        tbl[11] = '{16'hA020, 1'b1, 1'b0, 8'h00, 6'h00, 3, 8'h01};
        tbl[12] = '{16'hA020, 1'b0, 1'b1, 8'h10, 6'h00, 3, 8'h20};
        tbl[13] = '{16'hB000, 1'b0, 1'b0, 8'h01, 6'h00, 3, 8'h01};
        tbl[14] = '{16'hC000, 1'b0, 1'b0, 8'h01, 6'h00, 3, 8'h01};
        tbl[15] = '{16'hE000, 1'b0, 1'b0, 8'h01, 6'h00, 3, 8'h01};

        // Reset state
        #2;
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_strobes", 32'(all_strobes()), 32'd0);
        chk("reset_count", 32'(instr_count), 32'd0);
        do_reset();

        // Free-run LDI 0x2A then HLT
        ram[0] = 16'h102A; ram[1] = 16'hF000;
        exp_st = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd6};
        run_en = 1'b1;
        for (int c = 0; c < 7; c++) begin
            cyc();
            chk($sformatf("run_state_c%0d", c + 1), 32'(state_out), 32'(exp_st[c]));
            if (c == 2) chk("ldi_decode", 32'(dec_vec()), 32'h08);
        end
        chk("halted", 32'(halted), 32'd1);
        chk("halt_count", 32'(instr_count), 32'd1);
        run_en = 1'b0; step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        cyc();
        chk("halt_sticky", 32'(state_out), 32'd6);
        chk("halt_strobes", 32'(all_strobes()), 32'h0002);

        // Single-step vector table
        do_reset();
        for (int v = 0; v < 16; v++) begin
            ram[0] = tbl[v].instr;
            pc = 8'h00; ir = 16'h0000; opcode = 4'h0;
            acc_zero = tbl[v].az; carry_flag = tbl[v].cy;
            d = 8'h00; e = 6'h00; n = 0;
            step_req = 1'b1;
            cyc();
            step_req = 1'b0;
            while (state_out != 3'd0 && n < 20) begin
                if (state_out == 3'd3) d = dec_vec();
                if (state_out == 3'd5) e = exe_vec();
                n++;
                cyc();
            end
            exp_cnt++;
            chk($sformatf("v%0d_decode", v), 32'(d), 32'(tbl[v].dec));
            chk($sformatf("v%0d_exec", v), 32'(e), 32'(tbl[v].exe));
            chk($sformatf("v%0d_cycles", v), 32'(n), 32'(tbl[v].cycles));
            chk($sformatf("v%0d_pc", v), 32'(pc), 32'(tbl[v].pc_after));
            chk($sformatf("v%0d_count", v), 32'(instr_count), 32'(exp_cnt));
        end
        acc_zero = 1'b0; carry_flag = 1'b0;

        // ADD [5] single-step with a second step_req during MWAIT
        ram[0] = 16'h4005; ram[5] = 16'h0003;
        pc = 8'h00; ir = 16'h0000; opcode = 4'h0;
        cyc();
        chk("idle_quiet", 32'(state_out), 32'd0);
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        n = 0;
        while (state_out != 3'd4 && n < 10) begin n++; cyc(); end
        chk("add_reach_mwait", 32'(state_out), 32'd4);
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        chk("add_exec_state", 32'(state_out), 32'd5);
        chk("add_exec_vec", 32'(exe_vec()), 32'h31);
        cyc();
        chk("add_back_idle", 32'(state_out), 32'd0);
        cyc(); cyc();
        chk("step_dropped", 32'(state_out), 32'd0);
        exp_cnt++;
        chk("add_count", 32'(instr_count), 32'(exp_cnt));

        // Illegal opcode while free-running
        ram[0] = 16'hC000; ram[1] = 16'hF000;
        pc = 8'h00; ir = 16'h0000; opcode = 4'h0;
        run_en = 1'b1;
        cyc(); cyc(); cyc();
        chk("ill_decode_state", 32'(state_out), 32'd3);
        chk("ill_pulse", 32'(illegal), 32'd1);
        cyc();
        exp_cnt++;
        chk("ill_next_fetch", 32'(state_out), 32'd1);
        chk("ill_pulse_end", 32'(illegal), 32'd0);
        chk("ill_count", 32'(instr_count), 32'(exp_cnt));
        cyc(); cyc(); cyc();
        chk("ill_then_halt", 32'(state_out), 32'd6);
        run_en = 1'b0;

        // MEM_LATENCY=3: LDA takes 9 cycles, ir_load only in the last FWAIT cycle
        do_reset();
        st3  = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};
        ild3 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        op3 = 4'h2;
        step3 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            step3 = 1'b0;
            chk($sformatf("lat3_state_c%0d", c + 1), 32'(state3), 32'(st3[c]));
            chk($sformatf("lat3_irload_c%0d", c + 1), 32'(ir3_load), 32'(ild3[c]));
        end
        chk("lat3_count", 32'(cnt3), 32'd1);

        // Asynchronous reset while in MWAIT
        do_reset();
        ram[0] = 16'h2005;
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        n = 0;
        while (state_out != 3'd4 && n < 10) begin n++; cyc(); end
        chk("rst_reach_mwait", 32'(state_out), 32'd4);
        @(negedge clk_50mhz);
        #2;
        key0_n = 1'b0;
        #1;
        chk("rst_async_state", 32'(state_out), 32'd0);
        chk("rst_async_strobes", 32'(all_strobes()), 32'd0);
        chk("rst_async_count", 32'(instr_count), 32'd0);
        @(negedge clk_50mhz);
        key0_n = 1'b1;
        pc = 8'h00; ir = 16'h0000; opcode = 4'h0;
        cyc();
        chk("rst_release_idle", 32'(state_out), 32'd0);
        chk("rst_release_strobes", 32'(all_strobes()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
